// File: rtl/fp_pkg.sv
// Shared class enum, flag indices and constant builders for the FP multiplier.
package fp_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

  // Magnitude only (sign bit clear); callers prepend the sign.
  function automatic logic [63:0] fp_inf(input int e, input int m);
    return ((64'd1 << e) - 64'd1) << m;
  endfunction

  function automatic logic [63:0] fp_qnan(input int e, input int m);
    return fp_inf(e, m) | (64'd1 << (m - 1));
  endfunction

  // Subnormals fall into ZERO: they are flushed on input.
  function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic man_nz);
    if (exp_zero) return ZERO;
    if (exp_ones) return man_nz ? NAN : INF;
    return NORM;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of an M-bit fraction from guard/round/sticky; combinational.
module fp_round_rne #(
  parameter int M = 23
) (
  input  logic [M-1:0] mant,
  input  logic         guard,
  input  logic         round,
  input  logic         sticky,
  output logic [M-1:0] mant_rnd,
  output logic         carry
);

  logic up;

  assign up = guard & (round | sticky | mant[0]);
  assign {carry, mant_rnd} = {1'b0, mant} + {{M{1'b0}}, up};

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage stallable FP multiplier (RNE, specials, saturation), 3-cycle latency; all stages
// hold when out_valid & ~out_ready. FP_MUL_FLAGS_EN adds out_flags {invalid,overflow,underflow,inexact}.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int E          = 8,
  parameter int M          = 23,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_p,
`ifdef FP_MUL_FLAGS_EN
  output logic [FLAG_W-1:0]     out_flags,
`endif
  output logic [TAG_W-1:0]      out_tag
);

  localparam int EW = E + 2;
  localparam int PW = 2 * M + 2;
  localparam logic [DATA_WIDTH-1:0] QNAN     = DATA_WIDTH'(fp_qnan(E, M));
  localparam logic [DATA_WIDTH-2:0] INF_MAG  = (DATA_WIDTH - 1)'(fp_inf(E, M));
  localparam logic signed [EW-1:0]  BIAS     = EW'(fp_bias(E));
  localparam logic signed [EW-1:0]  EXP_MAX  = EW'((1 << E) - 1);
  localparam logic signed [EW-1:0]  EXP_ZERO = '0;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // S1: unpack and classify
  logic [E-1:0]          ea, eb;
  logic [M-1:0]          fa, fb;
  fp_class_t             ca, cb, c_in;
  logic signed [EW-1:0]  exp_in;

  assign ea = in_a[DATA_WIDTH-2 -: E];
  assign eb = in_b[DATA_WIDTH-2 -: E];
  assign fa = in_a[M-1:0];
  assign fb = in_b[M-1:0];
  assign ca = fp_classify(ea == '0, ea == '1, fa != '0);
  assign cb = fp_classify(eb == '0, eb == '1, fb != '0);
  assign exp_in = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  always_comb begin
    c_in = NORM;
    if (ca == NAN || cb == NAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF))
      c_in = NAN;
    else if (ca == INF || cb == INF)
      c_in = INF;
    else if (ca == ZERO || cb == ZERO)
      c_in = ZERO;
  end

  logic                 s1_vld, s2_vld;
  logic [TAG_W-1:0]     s1_tag, s2_tag;
  logic                 s1_sign, s2_sign;
  fp_class_t            s1_cls, s2_cls;
  logic signed [EW-1:0] s1_exp, s2_exp;
  logic [M:0]           s1_ma, s1_mb;
  logic [PW-1:0]        s2_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_tag  <= '0;
      s1_sign <= 1'b0;
      s1_cls  <= ZERO;
      s1_exp  <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
      s2_vld  <= 1'b0;
      s2_tag  <= '0;
      s2_sign <= 1'b0;
      s2_cls  <= ZERO;
      s2_exp  <= '0;
      s2_prod <= '0;
    end else if (adv) begin
      s1_vld  <= in_valid;
      s1_tag  <= in_tag;
      s1_sign <= in_a[DATA_WIDTH-1] ^ in_b[DATA_WIDTH-1];
      s1_cls  <= c_in;
      s1_exp  <= exp_in;
      s1_ma   <= {1'b1, fa};
      s1_mb   <= {1'b1, fb};
      s2_vld  <= s1_vld;
      s2_tag  <= s1_tag;
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_exp  <= s1_exp;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
    end
  end

  // S3: product is in [1,4); hi selects the one-bit right normalisation
  logic                 hi, guard, rnd, sticky, carry, ovf, udf;
  logic [M-1:0]         frac_n, frac_r;
  logic signed [EW-1:0] exp_n, exp_f;
  logic [DATA_WIDTH-1:0] p_nxt;

  assign hi     = s2_prod[PW-1];
  assign frac_n = hi ? s2_prod[PW-2 -: M] : s2_prod[PW-3 -: M];
  assign guard  = hi ? s2_prod[M]   : s2_prod[M-1];
  assign rnd    = hi ? s2_prod[M-1] : s2_prod[M-2];
  assign sticky = hi ? |s2_prod[M-2:0] : |s2_prod[M-3:0];
  assign exp_n  = s2_exp + EW'(hi);

  fp_round_rne #(.M(M)) u_round (
    .mant     (frac_n),
    .guard    (guard),
    .round    (rnd),
    .sticky   (sticky),
    .mant_rnd (frac_r),
    .carry    (carry)
  );

  assign exp_f = exp_n + EW'(carry);
  assign ovf   = exp_f >= EXP_MAX;
  assign udf   = exp_f <= EXP_ZERO;

  always_comb begin
    p_nxt = '0;
    case (s2_cls)
      NAN:  p_nxt = QNAN;
      INF:  p_nxt = {s2_sign, INF_MAG};
      ZERO: p_nxt = {s2_sign, {(DATA_WIDTH - 1){1'b0}}};
      default: begin
        if (ovf)      p_nxt = {s2_sign, INF_MAG};
        else if (udf) p_nxt = {s2_sign, {(DATA_WIDTH - 1){1'b0}}};
        else          p_nxt = {s2_sign, exp_f[E-1:0], frac_r};
      end
    endcase
  end

`ifdef FP_MUL_FLAGS_EN
  logic [FLAG_W-1:0] flags_nxt;

  always_comb begin
    flags_nxt                 = '0;
    flags_nxt[FLAG_INVALID]   = (s2_cls == NAN);
    flags_nxt[FLAG_OVERFLOW]  = (s2_cls == NORM) && ovf;
    flags_nxt[FLAG_UNDERFLOW] = (s2_cls == NORM) && !ovf && udf;
    flags_nxt[FLAG_INEXACT]   = (s2_cls == NORM) && (guard | rnd | sticky | ovf | udf);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
`ifdef FP_MUL_FLAGS_EN
      out_flags <= '0;
`endif
    end else if (adv) begin
      out_valid <= s2_vld;
      if (s2_vld) begin
        out_p     <= p_nxt;
        out_tag   <= s2_tag;
`ifdef FP_MUL_FLAGS_EN
        out_flags <= flags_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed table, backpressure, reset and randomized streams (FP32),
// plus an FP16 instance for the narrow-format vectors.
`timescale 1ns/1ps
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_p;
  logic [3:0]  in_tag, out_tag;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_p;
  logic [3:0]  h_tag, h_out_tag;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  out_flags, h_flags;
`endif

  fp_mul_pipe #(.DATA_WIDTH(32), .E(8), .M(23), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
`ifdef FP_MUL_FLAGS_EN
    .out_flags(out_flags),
`endif
    .out_tag(out_tag)
  );

  fp_mul_pipe #(.DATA_WIDTH(16), .E(5), .M(10), .TAG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_a(h_a), .in_b(h_b), .in_tag(h_tag),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_p(h_p),
`ifdef FP_MUL_FLAGS_EN
    .out_flags(h_flags),
`endif
    .out_tag(h_out_tag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [3:0]  f;
  } vec_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [3:0]  f;
    logic [31:0] p;
  } exp_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [3:0] f);
    vec_t v;
    v.a = a; v.b = b; v.p = p; v.f = f;
    vq.push_back(v);
  endtask

  // Reference: exact integer product, then RNE by comparing the remainder against half an ulp.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic s;
    logic [63:0] ma, mb, p, q, rem, half;
    bit an, bn, ai, bi, az, bz, inx;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (az && bi)) return {4'b1000, 32'h7FC0_0000};
    if (ai || bi) return {4'b0000, s, 8'hFF, 23'd0};
    if (az || bz) return {4'b0000, s, 31'd0};
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = ea + eb - 127;
    sh = 23;
    if (p >= 64'h8000_0000_0000) begin
      sh = 24;
      e  = e + 1;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == 64'h100_0000) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0011, s, 31'd0};
    return {3'b000, inx, s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [31:0] sp [9];
    int k;
    sp = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
           32'h0000_0001, 32'h7F7F_FFFF, 32'h0080_0000, 32'h3F80_0000};
    k = $urandom_range(0, 9);
    if (k < 6) return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    if (k < 8) return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    if (k == 8) return $urandom;
    return sp[$urandom_range(0, 8)];
  endfunction

  task automatic apply_one(input int idx, input vec_t v);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = v.a;
    in_b      = v.b;
    in_tag    = 4'(idx);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_early", idx), 64'(out_valid), 64'd0);
    @(negedge clk);
    chk($sformatf("vec%0d_valid", idx), 64'(out_valid), 64'd1);
    chk($sformatf("vec%0d_p", idx), 64'(out_p), 64'(v.p));
    chk($sformatf("vec%0d_tag", idx), 64'(out_tag), 64'(idx[3:0]));
`ifdef FP_MUL_FLAGS_EN
    chk($sformatf("vec%0d_flags", idx), 64'(out_flags), 64'(v.f));
`endif
  endtask

  // One op per loop pass at most; rnd randomizes valid/ready, otherwise out_ready drops in [st_lo,st_hi].
  task automatic stream(input int n, input bit rnd, input int st_lo, input int st_hi, input string nm);
    exp_t        q[$];
    exp_t        e;
    logic [35:0] r;
    logic [31:0] held_p;
    logic [3:0]  held_t;
    bit          held, acc;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; held = 0; acc = 0;
    held_p = '0; held_t = '0;
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_a     = gen_operand();
        in_b     = gen_operand();
        in_tag   = 4'(sent);
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= st_lo && cyc <= st_hi);
      #1;
      if (held) begin
        chk({nm, "_hold_p"}, 64'(out_p), 64'(held_p));
        chk({nm, "_hold_tag"}, 64'(out_tag), 64'(held_t));
      end
      held   = out_valid && !out_ready;
      held_p = out_p;
      held_t = out_tag;
      if (!rnd && cyc >= st_lo && cyc <= st_hi && out_valid)
        chk({nm, "_in_ready_stall"}, 64'(in_ready), 64'd0);
      if (!rnd && cyc > st_hi && got < n)
        chk({nm, "_contiguous"}, 64'(out_valid), 64'd1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk({nm, "_spurious"}, 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk({nm, "_p"}, 64'(out_p), 64'(e.p));
          chk({nm, "_tag"}, 64'(out_tag), 64'(e.tag));
`ifdef FP_MUL_FLAGS_EN
          chk({nm, "_flags"}, 64'(out_flags), 64'(e.f));
`endif
          got++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        r = ref_mul(in_a, in_b);
        e.tag = in_tag;
        e.f   = r[35:32];
        e.p   = r[31:0];
        q.push_back(e);
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (got < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d results expected %0d", nm, got, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ha [2];
    logic [15:0] hb [2];
    logic [15:0] hp [2];
    logic [3:0]  hf [2];
    int          bad;

    add_vec(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'h0);
    add_vec(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 4'h1);
    add_vec(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'h5);
    add_vec(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'h8);
    add_vec(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'h0);
    add_vec(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'h3);
    add_vec(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'h0);
    add_vec(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'h0);
    add_vec(32'hFF81_2345, 32'h3F80_0000, 32'h7FC0_0000, 4'h8);
    add_vec(32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'h8);
    add_vec(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'h0);
    add_vec(32'h3FFF_FFFE, 32'h3F80_0001, 32'h4000_0000, 4'h1);
    add_vec(32'h1F80_0000, 32'h1F80_0000, 32'h0000_0000, 4'h3);
    add_vec(32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 4'h0);
    add_vec(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 4'h0);
    add_vec(32'h3F80_0000, 32'h8000_0000, 32'h8000_0000, 4'h0);
    add_vec(32'hFFC0_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'h8);
    add_vec(32'hFF80_0000, 32'h8000_0000, 32'h7FC0_0000, 4'h8);

    ha = '{16'h3E00, 16'h3C01};
    hb = '{16'h4000, 16'h3E00};
    hp = '{16'h4200, 16'h3E02};
    hf = '{4'h0, 4'h1};

    rst_n = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_tag = 4'd9; h_out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_p", 64'(out_p), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
`ifdef FP_MUL_FLAGS_EN
    chk("reset_flags", 64'(out_flags), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < vq.size(); i++) apply_one(i, vq[i]);

    stream(8, 1'b0, 4, 9, "bp");

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = 32'h3FC0_0000;
      in_b      = 32'h4000_0000;
      in_tag    = 4'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_p", 64'(out_p), 64'd0);
    chk("rst_mid_tag", 64'(out_tag), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    chk("rst_no_stale", 64'(bad), 64'd0);
    apply_one(0, vq[0]);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      h_in_valid = 1'b1;
      h_a = ha[i];
      h_b = hb[i];
      @(negedge clk);
      h_in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("fp16_%0d_early", i), 64'(h_out_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("fp16_%0d_valid", i), 64'(h_out_valid), 64'd1);
      chk($sformatf("fp16_%0d_p", i), 64'(h_p), 64'(hp[i]));
      chk($sformatf("fp16_%0d_tag", i), 64'(h_out_tag), 64'd9);
`ifdef FP_MUL_FLAGS_EN
      chk($sformatf("fp16_%0d_flags", i), 64'(h_flags), 64'(hf[i]));
`endif
    end

    stream(300, 1'b1, 0, -1, "rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
